// File: rtl/vect_mem_pkg.sv
// Shared types and constants for the vector-memory port arbiter.
// The port is 256 bits wide, byte-addressed with 32-bit addresses.
package vect_mem_pkg;
  localparam int VLEN   = 256;
  localparam int ADDR_W = 32;
  localparam int LANE_W = 16;

  typedef logic [VLEN-1:0] vec_t;

  typedef enum logic {
    IDLE  = 1'b0,
    BURST = 1'b1
  } state_t;

  // A single requester still needs a 1-bit index.
  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/vect_mem_arbiter_rr_arbiter.sv
// Combinational round-robin picker: the first asserted request at or after ptr wins.
// Produces the winner as a one-hot vector, as an index, and as an any-request flag.
module rr_arbiter #(
  parameter int NREQ  = 2,
  parameter int IDX_W = 1
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] ptr,
  output logic [NREQ-1:0]  grant,
  output logic [IDX_W-1:0] idx,
  output logic             any
);
  always_comb begin
    int c;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    c     = 0;
    for (int i = 0; i < NREQ; i++) begin
      c = int'(ptr) + i;
      if (c >= NREQ) c = c - NREQ;
      if (!any && req[c]) begin
        any      = 1'b1;
        grant[c] = 1'b1;
        idx      = IDX_W'(c);
      end
    end
  end
endmodule

// File: rtl/vect_mem_arbiter.sv
// Round-robin arbiter sharing the single 256-bit vectmanager port between requesters.
// One strided burst per grant; read beats are registered and returned one cycle later.
module vect_mem_arbiter
  import vect_mem_pkg::*;
#(
  parameter int NREQ   = 2,
  parameter int LEN_W  = 4,
  parameter int STRIDE = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NREQ-1:0]         req_valid,
  input  logic [NREQ-1:0]         req_we,
  input  logic [NREQ*ADDR_W-1:0]  req_addr,
  input  logic [NREQ*LEN_W-1:0]   req_len,
  output logic [NREQ-1:0]         req_ready,
  input  logic [NREQ*VLEN-1:0]    wdata,
  input  logic [NREQ-1:0]         wdata_valid,
  output logic [NREQ-1:0]         wdata_ready,
  output logic [VLEN-1:0]         rdata,
  output logic [NREQ-1:0]         rdata_valid,
  output logic [NREQ-1:0]         done,
  output logic                    busy,
  output logic                    mem_we,
  output logic [ADDR_W-1:0]       mem_a,
  output logic [VLEN-1:0]         mem_wd,
  input  logic [VLEN-1:0]         mem_rd
);
  localparam int IDX_W = idx_width(NREQ);

  state_t             state_reg, state_next;
  logic [IDX_W-1:0]   rr_ptr_reg, own_reg;
  logic               we_reg;
  logic [ADDR_W-1:0]  base_reg;
  logic [LEN_W-1:0]   len_reg, beat_reg;
  vec_t               rdata_reg;
  logic [NREQ-1:0]    rdata_valid_reg, done_reg;

  logic [ADDR_W-1:0]  addr_arr  [NREQ];
  logic [LEN_W-1:0]   len_arr   [NREQ];
  vec_t               wdata_arr [NREQ];
  logic [NREQ-1:0]    own_onehot;

  logic [NREQ-1:0]    gnt;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_any;

  logic               in_burst, grant_fire, wv_own, beat_adv, last_beat;
  logic [ADDR_W-1:0]  beat_addr;
  logic [IDX_W-1:0]   rr_ptr_next;

  generate
    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
      assign addr_arr[gi]   = req_addr[gi*ADDR_W +: ADDR_W];
      assign len_arr[gi]    = req_len[gi*LEN_W +: LEN_W];
      assign wdata_arr[gi]  = wdata[gi*VLEN +: VLEN];
      assign own_onehot[gi] = (own_reg == IDX_W'(gi));
    end
  endgenerate

  rr_arbiter #(
    .NREQ  (NREQ),
    .IDX_W (IDX_W)
  ) u_arb (
    .req   (req_valid),
    .ptr   (rr_ptr_reg),
    .grant (gnt),
    .idx   (gnt_idx),
    .any   (gnt_any)
  );

  // Reset gates every port-facing action so an abandoned burst cannot write.
  assign in_burst    = (state_reg == BURST) && !reset;
  assign grant_fire  = (state_reg == IDLE) && gnt_any && !reset;
  assign wv_own      = wdata_valid[own_reg];
  assign beat_adv    = in_burst && (!we_reg || wv_own);
  assign last_beat   = beat_adv && (beat_reg == len_reg);
  assign beat_addr   = base_reg + ADDR_W'(beat_reg) * ADDR_W'(STRIDE);
  assign rr_ptr_next = (gnt_idx == IDX_W'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;

  always_ff @(posedge clk) begin
    if (reset) state_reg <= IDLE;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE:    if (grant_fire) state_next = BURST;
      BURST:   if (last_beat)  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = '0;
    wdata_ready = '0;
    mem_we      = 1'b0;
    mem_a       = '0;
    mem_wd      = '0;
    if (grant_fire) req_ready = gnt;
    if (in_burst) begin
      mem_a = beat_addr;
      if (we_reg) begin
        wdata_ready = own_onehot;
        mem_we      = wv_own;
        mem_wd      = wdata_arr[own_reg];
      end
    end
  end

  // Latched command, beat counter and read-return register.
  always_ff @(posedge clk) begin
    if (reset) begin
      rr_ptr_reg      <= '0;
      own_reg         <= '0;
      we_reg          <= 1'b0;
      base_reg        <= '0;
      len_reg         <= '0;
      beat_reg        <= '0;
      rdata_reg       <= '0;
      rdata_valid_reg <= '0;
      done_reg        <= '0;
    end else begin
      rdata_valid_reg <= '0;
      done_reg        <= '0;
      if (grant_fire) begin
        own_reg    <= gnt_idx;
        we_reg     <= req_we[gnt_idx];
        base_reg   <= addr_arr[gnt_idx];
        len_reg    <= len_arr[gnt_idx];
        beat_reg   <= '0;
        rr_ptr_reg <= rr_ptr_next;
      end
      if (beat_adv) begin
        beat_reg <= beat_reg + 1'b1;
        if (!we_reg) begin
          rdata_reg       <= mem_rd;
          rdata_valid_reg <= own_onehot;
        end
        if (last_beat) done_reg <= own_onehot;
      end
    end
  end

  assign busy        = (state_reg == BURST);
  assign rdata       = rdata_reg;
  assign rdata_valid = rdata_valid_reg;
  assign done        = done_reg;
endmodule
